// File: rtl/ff_bank_sequencer.sv
// Sequencer/checker for a bank of WIDTH D flip-flops: drives one strobe cycle,
// waits SETTLE cycles, samples the bank, and tracks sticky mismatch status.

module ff_bank_sequencer_lane (
  input  logic [1:0] i_cmd_op,
  input  logic       i_cmd_mask,
  input  logic       i_cmd_data,
  input  logic [1:0] i_op,
  input  logic       i_mask,
  input  logic       i_data,
  input  logic       i_samp,
  output logic       o_en,
  output logic       o_clr,
  output logic       o_pre,
  output logic       o_d,
  output logic       o_mism
);
  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;

  logic w_exp;

  // Strobe decode works on the live command so it can be registered at accept.
  assign o_en  = i_cmd_mask & (i_cmd_op == OP_LOAD);
  assign o_clr = i_cmd_mask & (i_cmd_op == OP_CLEAR);
  assign o_pre = i_cmd_mask & (i_cmd_op == OP_PRESET);
  assign o_d   = i_cmd_mask & i_cmd_data;

  // Compare works on the latched command and the sampled bank bit.
  assign w_exp  = (i_op == OP_CLEAR)  ? 1'b0 :
                  (i_op == OP_PRESET) ? 1'b1 : i_data;
  assign o_mism = i_mask & (i_samp ^ w_exp);
endmodule

module ff_bank_sequencer #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] ff_d,
  output logic [WIDTH-1:0] ff_en,
  output logic [WIDTH-1:0] ff_clr,
  output logic [WIDTH-1:0] ff_pre,
  input  logic [WIDTH-1:0] ff_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] mism,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);
  if (SETTLE < 0 || SETTLE > 15) begin : g_bad_settle
    $error("ff_bank_sequencer: SETTLE must be in 0..15");
  end

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [3:0] SETTLE_LD = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_samp;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_en;
  logic [WIDTH-1:0] r_clr;
  logic [WIDTH-1:0] r_pre;
  logic             r_done;
  logic             r_pass;
  logic [WIDTH-1:0] r_mism;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_en, w_clr, w_pre, w_d, w_mism;
  logic             w_accept;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    ff_bank_sequencer_lane u_lane (
      .i_cmd_op   (cmd_op),
      .i_cmd_mask (cmd_mask[g]),
      .i_cmd_data (cmd_data[g]),
      .i_op       (r_op),
      .i_mask     (r_mask[g]),
      .i_data     (r_data[g]),
      .i_samp     (r_samp[g]),
      .o_en       (w_en[g]),
      .o_clr      (w_clr[g]),
      .o_pre      (w_pre[g]),
      .o_d        (w_d[g]),
      .o_mism     (w_mism[g])
    );
  end

  assign w_accept = cmd_valid & (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_mask    <= '0;
      r_data    <= '0;
      r_samp    <= '0;
      r_d       <= '0;
      r_en      <= '0;
      r_clr     <= '0;
      r_pre     <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_mism    <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      r_en   <= '0;
      r_clr  <= '0;
      r_pre  <= '0;
      if (err_clr) begin
        r_err     <= 1'b0;
        r_err_cnt <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= cmd_op;
            r_mask  <= cmd_mask;
            r_data  <= cmd_data;
            r_en    <= w_en;
            r_clr   <= w_clr;
            r_pre   <= w_pre;
            if (cmd_op == OP_LOAD) r_d <= w_d;
            r_state <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (SETTLE == 0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt   <= SETTLE_LD;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) r_state <= S_SAMPLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_SAMPLE: begin
          r_samp  <= ff_q;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_pass <= ~|w_mism;
          r_mism <= w_mism;
          // A mismatch overrides a same-cycle err_clr and restarts the count at 1.
          if (|w_mism) begin
            r_err <= 1'b1;
            if (err_clr)              r_err_cnt <= CNT_W'(1);
            else if (&r_err_cnt)      r_err_cnt <= r_err_cnt;
            else                      r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign ff_d      = r_d;
  assign ff_en     = r_en;
  assign ff_clr    = r_clr;
  assign ff_pre    = r_pre;
  assign done      = r_done;
  assign pass      = r_pass;
  assign mism      = r_mism;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_ff_bank_sequencer.sv
// Randomized scoreboard bench for ff_bank_sequencer with a behavioural 3-bit bank
// (sync clear/preset, preset over clear) and an optional preset fault.

module tb_ff_bank_sequencer;
  localparam int W = 3;
  localparam int S = 1;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_mask, cmd_data;
  logic         err_clr;
  logic [W-1:0] ff_d, ff_en, ff_clr, ff_pre, ff_q;
  logic         busy, done, pass, err;
  logic [W-1:0] mism;
  logic [C-1:0] err_cnt;

  ff_bank_sequencer #(.WIDTH(W), .SETTLE(S), .CNT_W(C)) dut (
    .clk(clk), .clr_n(clr_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data), .err_clr(err_clr),
    .ff_d(ff_d), .ff_en(ff_en), .ff_clr(ff_clr), .ff_pre(ff_pre), .ff_q(ff_q),
    .busy(busy), .done(done), .pass(pass), .mism(mism), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Bank under control; fault=1 makes it ignore preset.
  logic [W-1:0] bank_q = '0;
  bit           fault  = 1'b0;
  assign ff_q = bank_q;
  always @(posedge clk)
    for (int i = 0; i < W; i++)
      if (ff_pre[i] && !fault) bank_q[i] <= 1'b1;
      else if (ff_clr[i])      bank_q[i] <= 1'b0;
      else if (ff_en[i])       bank_q[i] <= ff_d[i];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Reference model: abstract bank contents and error status.
  typedef struct {
    logic         pass;
    logic [W-1:0] mism;
    logic         err;
    logic [C-1:0] cnt;
    int           acc;
  } exp_t;
  exp_t sbq[$];

  logic [W-1:0] ref_q    = '0;
  logic         ref_err  = 1'b0;
  logic [C-1:0] ref_cnt  = '0;
  logic [W-1:0] last_d   = '0;
  int           prev_acc = 0;

  function automatic exp_t ref_step(logic [1:0] op, logic [W-1:0] m, logic [W-1:0] d, bit ec);
    exp_t r;
    logic [W-1:0] e;
    case (op)
      2'b00: begin ref_q = (ref_q & ~m) | (d & m); e = d; end
      2'b01: begin ref_q = ref_q & ~m; e = '0; end
      2'b10: begin if (!fault) ref_q = ref_q | m; e = '1; end
      default: e = d;
    endcase
    r.mism = (ref_q ^ e) & m;
    r.pass = (r.mism == '0);
    if (!r.pass) begin
      ref_err = 1'b1;
      if (ec)                 ref_cnt = 1;
      else if (ref_cnt != 15) ref_cnt = ref_cnt + 1;
    end else if (ec) begin
      ref_err = 1'b0;
      ref_cnt = '0;
    end
    r.err = ref_err;
    r.cnt = ref_cnt;
    r.acc = cyc;
    return r;
  endfunction

  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && done) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_pass",    32'(pass),    32'(e.pass));
        chk("done_mism",    32'(mism),    32'(e.mism));
        chk("done_err",     32'(err),     32'(e.err));
        chk("done_err_cnt", 32'(err_cnt), 32'(e.cnt));
        chk("done_latency", 32'(cyc - e.acc), 32'(S + 4));
      end
    end
  end

  // Called at a negedge; returns two negedges after the accept edge.
  task automatic send(logic [1:0] op, logic [W-1:0] m, logic [W-1:0] d,
                      bit keep, bit b2b, bit ec, bit abort);
    int t = 0;
    exp_t e;
    cmd_op = op; cmd_mask = m; cmd_data = d; cmd_valid = 1'b1; err_clr = ec;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=0 expected=1");
      cmd_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept_gap", 32'(cyc - prev_acc), 32'(S + 4));
    prev_acc = cyc;
    e = ref_step(op, m, d, ec);
    if (!abort) sbq.push_back(e);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_mask = W'($urandom); cmd_data = W'($urandom);
    if (op == 2'b00) last_d = d & m;
    chk("apply_strobes", 32'({ff_en, ff_clr, ff_pre, ff_d}),
        32'({(op == 2'b00) ? m : '0, (op == 2'b01) ? m : '0,
             (op == 2'b10) ? m : '0, last_d}));
    @(negedge clk);
    chk("strobes_idle", 32'({ff_en, ff_clr, ff_pre}), 32'(0));
  endtask

  task automatic wait_done_then_drop_clr();
    int t = 0;
    while (!done && t < 50) begin @(negedge clk); t++; end
    chk("err_clr_done_seen", 32'(done), 32'(1));
    err_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk("idle_reached", 32'(cmd_ready), 32'(1));
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_ready_busy"}, 32'({cmd_ready, busy}), 32'(2));
    chk({tag, "_strobes"},    32'({ff_en, ff_clr, ff_pre, ff_d}), 32'(0));
    chk({tag, "_status"},     32'({done, pass, mism, err, err_cnt}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_data = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    clr_n  = 1'b1;
    mon_en = 1'b1;

    // Directed: load/check, clear, failing check.
    send(2'b00, 3'b111, 3'b101, 0, 0, 0, 0);
    send(2'b11, 3'b111, 3'b101, 0, 0, 0, 0);
    send(2'b00, 3'b111, 3'b111, 0, 0, 0, 0);
    send(2'b01, 3'b010, 3'b000, 0, 0, 0, 0);
    send(2'b11, 3'b111, 3'b101, 0, 0, 0, 0);
    send(2'b11, 3'b111, 3'b111, 0, 0, 0, 0);
    send(2'b11, 3'b000, 3'b111, 0, 0, 0, 0);

    // Preset fault until the counter saturates.
    fault = 1'b1;
    send(2'b01, 3'b001, 3'b000, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) send(2'b10, 3'b001, 3'b000, 0, 0, 0, 0);
    wait_idle();
    @(negedge clk);
    fault = 1'b0;
    chk("err_cnt_saturated", 32'(err_cnt), 32'(15));

    // Idle err_clr pulse.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    ref_err = 1'b0; ref_cnt = '0;
    chk("err_clr_idle", 32'({err, err_cnt}), 32'(0));

    // err_clr held across a mismatching command: mismatch wins with count 1.
    send(2'b00, 3'b111, 3'b000, 0, 0, 0, 0);
    send(2'b11, 3'b111, 3'b110, 0, 0, 1, 0);
    wait_done_then_drop_clr();

    // Held cmd_valid with mid-command field changes, then back-to-back issue.
    send(2'b00, 3'b111, 3'b011, 1, 0, 0, 0);
    send(2'b11, 3'b111, 3'b011, 1, 1, 0, 0);
    send(2'b10, 3'b100, 3'b000, 0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]   op;
      logic [W-1:0] m, d;
      bit           k;
      op = 2'($urandom); m = W'($urandom); d = W'($urandom);
      k  = ($urandom_range(0, 3) == 0);
      send(op, m, d, k, 0, 0, 0);
    end
    wait_idle();
    @(negedge clk);
    @(negedge clk);

    // Reset during SETTLE: command dropped, no done pulse.
    begin
      int nd = 0;
      send(2'b00, 3'b111, 3'b010, 0, 0, 0, 1);
      clr_n = 1'b0;
      @(negedge clk);
      check_reset_state("mid_reset");
      clr_n = 1'b1;
      ref_err = 1'b0; ref_cnt = '0; last_d = '0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (done) nd++;
      end
      chk("abort_no_done", 32'(nd), 32'(0));
    end

    // Bank must still hold the aborted load since its strobe had already fired.
    send(2'b11, 3'b111, 3'b010, 0, 0, 0, 0);
    send(2'b11, 3'b111, 3'b101, 0, 0, 0, 0);

    begin
      int t = 0;
      while (sbq.size() != 0 && t < 100) begin @(negedge clk); t++; end
    end
    chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
